// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback unit: FSM states and
// the funct3 encodings that select load width and sign handling.
package wb_pkg;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_LOAD = 1'b1
    } wb_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/load_extract.sv
// Combinational load-data alignment: picks the byte/halfword addressed by
// the low address bits and sign- or zero-extends it according to funct3.
module load_extract
    import wb_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = i_rdata[7:0];
        case (i_addr_lo)
            2'd0: byte_sel = i_rdata[7:0];
            2'd1: byte_sel = i_rdata[15:8];
            2'd2: byte_sel = i_rdata[23:16];
            2'd3: byte_sel = i_rdata[31:24];
            default: byte_sel = i_rdata[7:0];
        endcase
        half_sel = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            LB:      o_data = {{24{byte_sel[7]}}, byte_sel};
            LH:      o_data = {{16{half_sel[15]}}, half_sel};
            LW:      o_data = i_rdata;
            LBU:     o_data = {24'd0, byte_sel};
            LHU:     o_data = {16'd0, half_sel};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: retires ALU results immediately and waits for load data,
// with a timeout on missing load responses and a decode hazard flag.
module wb_unit
    import wb_pkg::*;
#(
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_load,
    input  logic [4:0]  i_req_rd,
    input  logic [31:0] i_req_data,
    input  logic [2:0]  i_req_funct3,
    input  logic [1:0]  i_req_addr_lo,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_rd_wen,
    output logic [4:0]  o_rd_waddr,
    output logic [31:0] o_rd_wdata,
    input  logic [4:0]  i_rs1_raddr,
    input  logic [4:0]  i_rs2_raddr,
    output logic        o_hazard,
    output logic        o_load_err
);

    localparam int unsigned CW = (LOAD_TIMEOUT < 2) ? 1 : $clog2(LOAD_TIMEOUT);
    // Counter value on the last permitted wait cycle without data.
    localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

    wb_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]  pend_rd_q, pend_rd_d;
    logic [2:0]  pend_f3_q, pend_f3_d;
    logic [1:0]  pend_alo_q, pend_alo_d;
    logic        wen_q, wen_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] ext_data;

    load_extract u_extract (
        .i_funct3  (pend_f3_q),
        .i_addr_lo (pend_alo_q),
        .i_rdata   (i_dmem_rdata),
        .o_data    (ext_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_rd_d  = pend_rd_q;
        pend_f3_d  = pend_f3_q;
        pend_alo_d = pend_alo_q;
        wen_d      = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    if (i_req_load) begin
                        pend_rd_d  = i_req_rd;
                        pend_f3_d  = i_req_funct3;
                        pend_alo_d = i_req_addr_lo;
                        cnt_d      = '0;
                        state_d    = ST_WAIT_LOAD;
                    end else if (i_req_rd != '0) begin
                        wen_d   = 1'b1;
                        waddr_d = i_req_rd;
                        wdata_d = i_req_data;
                    end
                end
            end
            ST_WAIT_LOAD: begin
                // Data wins over timeout when both land on the same cycle.
                if (i_dmem_rvalid) begin
                    state_d = ST_IDLE;
                    if (pend_rd_q != '0) begin
                        wen_d   = 1'b1;
                        waddr_d = pend_rd_q;
                        wdata_d = ext_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pend_rd_q  <= '0;
            pend_f3_q  <= '0;
            pend_alo_q <= '0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_rd_q  <= pend_rd_d;
            pend_f3_q  <= pend_f3_d;
            pend_alo_q <= pend_alo_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_rd_wen    = wen_q;
    assign o_rd_waddr  = waddr_q;
    assign o_rd_wdata  = wdata_q;
    assign o_load_err  = err_q;
    assign o_hazard    = (state_q == ST_WAIT_LOAD) && (pend_rd_q != '0) &&
                         ((i_rs1_raddr == pend_rd_q) || (i_rs2_raddr == pend_rd_q));

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: directed scenarios, an extraction table,
// and random traffic compared against a transaction-level reference model.
module tb_wb_unit;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_load, dmem_rvalid;
    logic [4:0]  req_rd, rs1, rs2;
    logic [31:0] req_data, dmem_rdata;
    logic [2:0]  req_f3;
    logic [1:0]  req_alo;
    logic        req_ready, rd_wen, hazard, load_err;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;

    int checks = 0;
    int failures = 0;

    wb_unit #(.LOAD_TIMEOUT(TMO)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_load    (req_load),
        .i_req_rd      (req_rd),
        .i_req_data    (req_data),
        .i_req_funct3  (req_f3),
        .i_req_addr_lo (req_alo),
        .i_dmem_rvalid (dmem_rvalid),
        .i_dmem_rdata  (dmem_rdata),
        .o_rd_wen      (rd_wen),
        .o_rd_waddr    (rd_waddr),
        .o_rd_wdata    (rd_wdata),
        .i_rs1_raddr   (rs1),
        .i_rs2_raddr   (rs2),
        .o_hazard      (hazard),
        .o_load_err    (load_err)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding load plus the last write seen.
    bit          m_pend;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_alo;
    int unsigned m_waited;
    logic        e_wen, e_err;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;

    function automatic logic [31:0] ref_extract(input logic [2:0] f3, input logic [1:0] alo,
                                                input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * alo)) & 32'hFF;
        h = (w >> (16 * (alo / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pend = 0; m_waited = 0; m_rd = '0; m_f3 = '0; m_alo = '0;
        e_wen = 0; e_err = 0; e_waddr = '0; e_wdata = '0;
    endtask

    task automatic m_step();
        e_wen = 0;
        e_err = 0;
        if (!rst_n) begin
            m_reset();
        end else if (!m_pend) begin
            if (req_valid && req_load) begin
                m_pend = 1; m_rd = req_rd; m_f3 = req_f3; m_alo = req_alo; m_waited = 0;
            end else if (req_valid && req_rd != 0) begin
                e_wen = 1; e_waddr = req_rd; e_wdata = req_data;
            end
        end else begin
            m_waited++;
            if (dmem_rvalid) begin
                m_pend = 0;
                if (m_rd != 0) begin
                    e_wen = 1; e_waddr = m_rd; e_wdata = ref_extract(m_f3, m_alo, dmem_rdata);
                end
            end else if (m_waited == TMO) begin
                m_pend = 0;
                e_err = 1;
            end
        end
    endtask

    // Compare all outputs mid-cycle, advance the model, then take the edge.
    task automatic tick();
        logic exp_hz;
        @(negedge clk);
        exp_hz = m_pend && (m_rd != 0) && (rs1 == m_rd || rs2 == m_rd);
        check("m_ready", {31'd0, req_ready}, {31'd0, !m_pend});
        check("m_hazard", {31'd0, hazard}, {31'd0, exp_hz});
        check("m_wen", {31'd0, rd_wen}, {31'd0, e_wen});
        check("m_err", {31'd0, load_err}, {31'd0, e_err});
        check("m_waddr", {27'd0, rd_waddr}, {27'd0, e_waddr});
        check("m_wdata", rd_wdata, e_wdata);
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_load = 0; req_rd = '0; req_data = '0; req_f3 = '0;
        req_alo = '0; dmem_rvalid = 0; dmem_rdata = '0; rs1 = '0; rs2 = '0;
    endtask

    task automatic send(input logic load, input logic [4:0] rd, input logic [31:0] data,
                        input logic [2:0] f3, input logic [1:0] alo);
        req_valid = 1; req_load = load; req_rd = rd; req_data = data;
        req_f3 = f3; req_alo = alo;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ext_vec_t;

    ext_vec_t vecs[12];

    initial begin
        vecs[0]  = '{3'b000, 2'd2, 32'h12803456, 32'hFFFFFF80};
        vecs[1]  = '{3'b101, 2'd2, 32'hBEEF1234, 32'h0000BEEF};
        vecs[2]  = '{3'b000, 2'd0, 32'h12803456, 32'h00000056};
        vecs[3]  = '{3'b100, 2'd2, 32'h12803456, 32'h00000080};
        vecs[4]  = '{3'b001, 2'd0, 32'hBEEF8234, 32'hFFFF8234};
        vecs[5]  = '{3'b001, 2'd2, 32'h7FFF0000, 32'h00007FFF};
        vecs[6]  = '{3'b010, 2'd1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[7]  = '{3'b011, 2'd3, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[8]  = '{3'b100, 2'd3, 32'hF1000000, 32'h000000F1};
        vecs[9]  = '{3'b000, 2'd1, 32'h0000FF00, 32'hFFFFFFFF};
        vecs[10] = '{3'b110, 2'd0, 32'h01234567, 32'h01234567};
        vecs[11] = '{3'b101, 2'd0, 32'hBEEF8234, 32'h00008234};

        rst_n = 0;
        idle_inputs();
        m_reset();
        #1;
        check("rst_wen", {31'd0, rd_wen}, 32'd0);
        check("rst_waddr", {27'd0, rd_waddr}, 32'd0);
        check("rst_wdata", rd_wdata, 32'd0);
        check("rst_err", {31'd0, load_err}, 32'd0);
        check("rst_hazard", {31'd0, hazard}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        tick(); tick();
        rst_n = 1;
        tick();

        // Back-to-back ALU writes.
        send(0, 5'd5, 32'h11, 3'd0, 2'd0);
        tick();
        send(0, 5'd6, 32'h22, 3'd0, 2'd0);
        check("b2b_wen1", {31'd0, rd_wen}, 32'd1);
        check("b2b_addr1", {27'd0, rd_waddr}, 32'd5);
        check("b2b_data1", rd_wdata, 32'h11);
        check("b2b_ready1", {31'd0, req_ready}, 32'd1);
        tick();
        idle_inputs();
        check("b2b_wen2", {31'd0, rd_wen}, 32'd1);
        check("b2b_addr2", {27'd0, rd_waddr}, 32'd6);
        check("b2b_data2", rd_wdata, 32'h22);
        tick();
        check("b2b_hold_addr", {27'd0, rd_waddr}, 32'd6);
        check("b2b_hold_data", rd_wdata, 32'h22);

        // LB with data three cycles after acceptance, hazard during the wait.
        send(1, 5'd7, 32'h0, 3'b000, 2'd2);
        tick();
        idle_inputs();
        rs1 = 5'd7;
        #1;
        check("lb_hazard", {31'd0, hazard}, 32'd1);
        check("lb_ready", {31'd0, req_ready}, 32'd0);
        tick(); tick();
        dmem_rvalid = 1; dmem_rdata = 32'h12803456;
        tick();
        dmem_rvalid = 0;
        check("lb_wen", {31'd0, rd_wen}, 32'd1);
        check("lb_addr", {27'd0, rd_waddr}, 32'd7);
        check("lb_data", rd_wdata, 32'hFFFFFF80);
        check("lb_ready_wr", {31'd0, req_ready}, 32'd1);
        check("lb_hazard_off", {31'd0, hazard}, 32'd0);
        tick();
        idle_inputs();

        // LHU with an ALU request stalled behind it.
        send(1, 5'd8, 32'h0, 3'b101, 2'd2);
        tick();
        send(0, 5'd9, 32'h99, 3'd0, 2'd0);
        #1;
        check("lhu_stall_ready", {31'd0, req_ready}, 32'd0);
        tick(); tick();
        dmem_rvalid = 1; dmem_rdata = 32'hBEEF1234;
        tick();
        dmem_rvalid = 0;
        check("lhu_data", rd_wdata, 32'h0000BEEF);
        check("lhu_addr", {27'd0, rd_waddr}, 32'd8);
        check("lhu_ready", {31'd0, req_ready}, 32'd1);
        tick();
        idle_inputs();
        check("stalled_alu_data", rd_wdata, 32'h99);
        check("stalled_alu_addr", {27'd0, rd_waddr}, 32'd9);
        tick();

        // Timeout with no data at all.
        send(1, 5'd10, 32'h0, 3'b010, 2'd0);
        tick();
        idle_inputs();
        for (int i = 0; i < int'(TMO); i++) begin
            check("tmo_no_err_early", {31'd0, load_err}, 32'd0);
            tick();
        end
        check("tmo_err", {31'd0, load_err}, 32'd1);
        check("tmo_no_wen", {31'd0, rd_wen}, 32'd0);
        check("tmo_ready", {31'd0, req_ready}, 32'd1);
        tick();
        check("tmo_err_pulse", {31'd0, load_err}, 32'd0);

        // Data arriving on the final wait cycle beats the timeout.
        send(1, 5'd11, 32'h0, 3'b010, 2'd0);
        tick();
        idle_inputs();
        for (int i = 0; i < int'(TMO) - 1; i++) tick();
        dmem_rvalid = 1; dmem_rdata = 32'hA5A55A5A;
        tick();
        dmem_rvalid = 0;
        check("tmo_race_wen", {31'd0, rd_wen}, 32'd1);
        check("tmo_race_data", rd_wdata, 32'hA5A55A5A);
        check("tmo_race_err", {31'd0, load_err}, 32'd0);
        tick();

        // rd = 0 for both kinds.
        send(0, 5'd0, 32'h77, 3'd0, 2'd0);
        tick();
        idle_inputs();
        check("rd0_alu_wen", {31'd0, rd_wen}, 32'd0);
        send(1, 5'd0, 32'h0, 3'b010, 2'd0);
        tick();
        idle_inputs();
        dmem_rvalid = 1; dmem_rdata = 32'h55;
        #1;
        check("rd0_hazard", {31'd0, hazard}, 32'd0);
        tick();
        dmem_rvalid = 0;
        check("rd0_load_wen", {31'd0, rd_wen}, 32'd0);
        check("rd0_load_ready", {31'd0, req_ready}, 32'd1);
        tick();

        // Reset in the middle of a load, then a stale response.
        send(1, 5'd12, 32'h0, 3'b010, 2'd0);
        tick();
        idle_inputs();
        rs2 = 5'd12;
        tick();
        #2;
        rst_n = 0;
        m_reset();
        #1;
        check("mid_rst_wen", {31'd0, rd_wen}, 32'd0);
        check("mid_rst_waddr", {27'd0, rd_waddr}, 32'd0);
        check("mid_rst_wdata", rd_wdata, 32'd0);
        check("mid_rst_hazard", {31'd0, hazard}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        tick();
        rst_n = 1;
        dmem_rvalid = 1; dmem_rdata = 32'hDEAD0000;
        tick();
        dmem_rvalid = 0;
        check("late_rvalid_wen", {31'd0, rd_wen}, 32'd0);
        check("late_rvalid_data", rd_wdata, 32'd0);
        tick();

        // Extraction table.
        for (int i = 0; i < 12; i++) begin
            send(1, 5'(i + 1), 32'h0, vecs[i].f3, vecs[i].alo);
            tick();
            idle_inputs();
            dmem_rvalid = 1; dmem_rdata = vecs[i].rdata;
            tick();
            dmem_rvalid = 0;
            check("tbl_wen", {31'd0, rd_wen}, 32'd1);
            check("tbl_data", rd_wdata, vecs[i].exp);
        end
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            req_valid   = ($urandom_range(0, 1) == 1);
            req_load    = ($urandom_range(0, 1) == 1);
            req_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            req_data    = $urandom;
            req_f3      = 3'($urandom);
            req_alo     = 2'($urandom);
            dmem_rvalid = ($urandom_range(0, 4) == 0);
            dmem_rdata  = $urandom;
            rs1         = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom);
            rs2         = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom);
            tick();
        end
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter LOAD_TIMEOUT, default 255: maximum number of WAIT_LOAD cycles before the load is abandoned.
REQ-002 SHALL have port i_clk, input, 1, the single global clock.
REQ-003 SHALL have port i_rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port i_req_valid, input, 1, a writeback request is present.
REQ-005 SHALL have port o_req_ready, output, 1, the unit accepts a request this cycle.
REQ-006 SHALL have port i_req_load, input, 1, request kind: 1=load, 0=ALU result.
REQ-007 SHALL have port i_req_rd, input, 5, destination register.
REQ-008 SHALL have port i_req_data, input, 32, ALU result; ignored for loads.
REQ-009 SHALL have port i_req_funct3, input, 3, load width and sign encoding.
REQ-010 SHALL have port i_req_addr_lo, input, 2, byte offset of the load address.
REQ-011 SHALL have port i_dmem_rvalid, input, 1, load data valid.
REQ-012 SHALL have port i_dmem_rdata, input, 32, raw load word.
REQ-013 SHALL have ports o_rd_wen (1), o_rd_waddr (5) and o_rd_wdata (32), all outputs, forming the register-file write port.
REQ-014 SHALL have ports i_rs1_raddr and i_rs2_raddr, inputs, 5 each, decode-stage read addresses.
REQ-015 SHALL have port o_hazard, output, 1, a decode read depends on a pending load.
REQ-016 SHALL have port o_load_err, output, 1, a load timed out.

Function
REQ-017 SHALL implement states IDLE and WAIT_LOAD; o_req_ready = (state==IDLE).
REQ-018 SHALL accept a request on the cycle where i_req_valid && o_req_ready.
REQ-019 SHALL, for an accepted ALU request, assert o_rd_wen for exactly the next cycle with o_rd_waddr=rd and o_rd_wdata=data, and remain in IDLE, so back-to-back requests are accepted every cycle.
REQ-020 SHALL, for an accepted load, capture rd, funct3 and addr_lo, clear the timeout counter, and enter WAIT_LOAD.
REQ-021 SHALL, on i_dmem_rvalid in WAIT_LOAD, write the extracted data on the next cycle and return to IDLE; o_req_ready is high in that write cycle.
REQ-022 SHALL extract by funct3 as follows:
  - 000: byte at offset addr_lo*8, sign-extended.
  - 001: halfword at offset addr_lo[1]*16, sign-extended.
  - 010: full word.
  - 100: byte as for 000, zero-extended.
  - 101: halfword as for 001, zero-extended.
  - Any other encoding: full word.
REQ-023 SHALL suppress o_rd_wen when rd==0 for either kind; the transaction otherwise completes normally.
REQ-024 SHALL ignore i_dmem_rvalid while in IDLE.
REQ-025 SHALL increment the counter on each WAIT_LOAD cycle without rvalid. On reaching LOAD_TIMEOUT it SHALL pulse o_load_err for one cycle, perform no write, and return to IDLE.
REQ-026 SHALL give rvalid priority over timeout when both occur in the same cycle (normal write, no error).
REQ-027 SHALL drive o_hazard combinationally as: state==WAIT_LOAD && pending_rd!=0 && (rs1==pending_rd || rs2==pending_rd).
REQ-028 SHALL hold o_rd_waddr and o_rd_wdata stable whenever o_rd_wen is low; registered values are acceptable.

Reset
REQ-029 SHALL, while i_rst_n is low, immediately force the following:
  - State IDLE and counter 0.
  - o_rd_wen, o_rd_waddr, o_rd_wdata, o_load_err and o_hazard all 0.
  - o_req_ready 1.
REQ-030 SHALL abandon a pending load when reset asserts mid-WAIT_LOAD; no write occurs after reset release.

Structure
REQ-031 SHALL place the state encoding and the funct3 load constants (LB, LH, LW, LBU, LHU) in shared package wb_pkg.
REQ-032 SHALL implement extraction in combinational sub-module load_extract (inputs: funct3, addr_lo, rdata; output: 32-bit data).

Verification
REQ-033 SHALL cover back-to-back ALU requests: rd=5/0x11, then rd=6/0x22 -> wen on consecutive cycles with matching addr and data; o_req_ready stays 1.
REQ-034 SHALL cover an LB load with addr_lo=2 and rdata=0x12_80_34_56, rvalid 3 cycles later -> write 0xFFFFFF80 one cycle after rvalid; o_hazard=1 while rs1=rd during the wait.
REQ-035 SHALL cover an LHU load with addr_lo=2 and rdata=0xBEEF1234 -> 0x0000BEEF; an ALU request during the wait is stalled (ready=0) and then accepted.
REQ-036 SHALL cover a timeout with LOAD_TIMEOUT=4 and no rvalid -> o_load_err pulses once, no wen, ready=1 on the next cycle; rvalid arriving on the timeout cycle -> normal write instead.
REQ-037 SHALL cover rd=0 with either kind -> no wen; and reset asserted during WAIT_LOAD followed by a late rvalid -> no write, all outputs 0.
